// File: rtl/rs232_tx_fifo.sv
// Buffered RS-232 transmitter: a small byte FIFO feeding an 8-bit async frame serialiser.
// All logic runs on the divided bit clock Dclk, in the same domain as the receive path.
module rs232_tx_fifo #(
  parameter int OVERSAMPLE = 1,
  parameter int DEPTH_LOG2 = 3,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  Dclk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf,
  output logic                  busy,
  output logic                  tx
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int OS_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0]     OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [2:0]          STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [DEPTH_LOG2:0] LVL_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  full_q, empty_q, ovf_q;

  state_t                state_q;
  logic [OS_W-1:0]       os_cnt_q;
  logic [2:0]            bit_cnt_q;
  logic [7:0]            shreg_q;
  logic                  par_q, tx_q, busy_q;

  logic [7:0]            head;
  logic                  push, pop, os_last, stop_done;

  assign head      = mem_q[rd_ptr_q];
  assign push      = wr_en & ~full_q;
  assign os_last   = (os_cnt_q == OS_LAST);
  assign stop_done = os_last && (bit_cnt_q == STOP_LAST);
  // Pops happen only on the edge where the serialiser loads a new byte.
  assign pop       = ~empty_q && ((state_q == S_IDLE) || ((state_q == S_STOP) && stop_done));

  always_comb begin
    level_d = level_q;
    if (push && !pop)
      level_d = level_q + 1'b1;
    else if (pop && !push)
      level_d = level_q - 1'b1;
  end

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge Dclk) begin
    if (push)
      mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge Dclk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == LVL_FULL);
      empty_q <= (level_d == '0);
      if (wr_en && full_q)
        ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge Dclk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q     <= 1'b1;
          busy_q   <= 1'b0;
          os_cnt_q <= '0;
          if (!empty_q) begin
            shreg_q <= head;
            par_q   <= ^head;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (os_last) begin
            os_cnt_q  <= '0;
            tx_q      <= shreg_q[0];
            shreg_q   <= shreg_q >> 1;
            bit_cnt_q <= '0;
            state_q   <= S_DATA;
          end else begin
            os_cnt_q <= os_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (os_last) begin
            os_cnt_q <= '0;
            if (bit_cnt_q == 3'd7) begin
              if (PARITY != 0) begin
                tx_q    <= (PARITY == 2) ? par_q : ~par_q;
                state_q <= S_PAR;
              end else begin
                tx_q      <= 1'b1;
                bit_cnt_q <= '0;
                state_q   <= S_STOP;
              end
            end else begin
              tx_q      <= shreg_q[0];
              shreg_q   <= shreg_q >> 1;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            os_cnt_q <= os_cnt_q + 1'b1;
          end
        end
        S_PAR: begin
          if (os_last) begin
            os_cnt_q  <= '0;
            tx_q      <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= S_STOP;
          end else begin
            os_cnt_q <= os_cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          // bit_cnt_q counts stop bits here; a waiting byte starts with no idle gap.
          if (os_last) begin
            os_cnt_q <= '0;
            if (bit_cnt_q == STOP_LAST) begin
              bit_cnt_q <= '0;
              if (!empty_q) begin
                shreg_q <= head;
                par_q   <= ^head;
                tx_q    <= 1'b0;
                state_q <= S_START;
              end else begin
                tx_q    <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            os_cnt_q <= os_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;
  assign ovf   = ovf_q;
  assign busy  = busy_q;
  assign tx    = tx_q;

endmodule

// File: tb/tb_rs232_tx_fifo.sv
// Directed bench for rs232_tx_fifo: four configurations, expected tx bits queued at write time
// and compared cycle by cycle as the line is sampled on the falling edge.
module tb_rs232_tx_fifo;

  logic       Dclk = 1'b0;
  logic       rst;
  logic [3:0] wr_en_v;
  logic [7:0] wr_data;
  logic [3:0] full_v, empty_v, ovf_v, busy_v, tx_v;
  logic [3:0] level_0, level_1, level_2, level_3;

  int par_cfg  [4] = '{0, 2, 1, 0};
  int os_cfg   [4] = '{1, 1, 1, 4};
  int stop_cfg [4] = '{1, 1, 1, 2};

  int   checks = 0;
  int   errors = 0;
  int   sel = 0;
  bit   mon_on = 0;
  int   lvl_max = 0;
  logic exp_q [$];

  always #5 Dclk = ~Dclk;

  rs232_tx_fifo u_plain (.Dclk(Dclk), .rst(rst), .wr_en(wr_en_v[0]), .wr_data(wr_data),
    .full(full_v[0]), .empty(empty_v[0]), .level(level_0), .ovf(ovf_v[0]), .busy(busy_v[0]), .tx(tx_v[0]));
  rs232_tx_fifo #(.PARITY(2)) u_even (.Dclk(Dclk), .rst(rst), .wr_en(wr_en_v[1]), .wr_data(wr_data),
    .full(full_v[1]), .empty(empty_v[1]), .level(level_1), .ovf(ovf_v[1]), .busy(busy_v[1]), .tx(tx_v[1]));
  rs232_tx_fifo #(.PARITY(1)) u_odd (.Dclk(Dclk), .rst(rst), .wr_en(wr_en_v[2]), .wr_data(wr_data),
    .full(full_v[2]), .empty(empty_v[2]), .level(level_2), .ovf(ovf_v[2]), .busy(busy_v[2]), .tx(tx_v[2]));
  rs232_tx_fifo #(.OVERSAMPLE(4), .STOP_BITS(2)) u_os (.Dclk(Dclk), .rst(rst), .wr_en(wr_en_v[3]),
    .wr_data(wr_data), .full(full_v[3]), .empty(empty_v[3]), .level(level_3), .ovf(ovf_v[3]),
    .busy(busy_v[3]), .tx(tx_v[3]));

  function automatic logic [3:0] lvl_m();
    case (sel)
      0:       return level_0;
      1:       return level_1;
      2:       return level_2;
      default: return level_3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, sel, obs, want);
    end
  endtask

  // Expected line for one frame of the selected instance, each bit held os_cfg cycles.
  task automatic push_frame(input logic [7:0] b);
    logic bits [$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (par_cfg[sel] == 2) bits.push_back(^b);
    if (par_cfg[sel] == 1) bits.push_back(~^b);
    for (int i = 0; i < stop_cfg[sel]; i++) bits.push_back(1'b1);
    foreach (bits[i])
      for (int k = 0; k < os_cfg[sel]; k++) exp_q.push_back(bits[i]);
  endtask

  task automatic tick();
    logic e;
    @(negedge Dclk);
    if (mon_on) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tx_bit", tx_v[sel], e);
      end else begin
        chk("tx_idle", tx_v[sel], 1);
        chk("busy_idle", busy_v[sel], 0);
      end
      if (int'(lvl_m()) > lvl_max) lvl_max = int'(lvl_m());
    end
  endtask

  // One-cycle write; lat adds the idle cycle before an idle transmitter reacts.
  task automatic send(input logic [7:0] b, input bit lat);
    wr_data = b;
    wr_en_v[sel] = 1'b1;
    if (lat) exp_q.push_back(1'b1);
    push_frame(b);
    tick();
    wr_en_v = '0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_tx"}, tx_v[sel], 1);
    chk({tag, "_busy"}, busy_v[sel], 0);
    chk({tag, "_empty"}, empty_v[sel], 1);
    chk({tag, "_full"}, full_v[sel], 0);
    chk({tag, "_level"}, lvl_m(), 0);
    chk({tag, "_ovf"}, ovf_v[sel], 0);
  endtask

  initial begin
    rst = 1'b0;
    wr_en_v = '0;
    wr_data = '0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      sel = i;
      chk_reset_state("por");
    end
    rst = 1'b1;
    sel = 0;
    mon_on = 1;
    tick();

    // 0x55 from idle: alternating line, then idle.
    send(8'h55, 1);
    repeat (14) tick();

    // Back-to-back frames with no idle gap; level never exceeds 1.
    lvl_max = 0;
    send(8'h00, 1);
    send(8'hFF, 0);
    repeat (22) tick();
    chk("b2b_lvl_max", lvl_max, 1);

    // Overflow: 0x09 is the ninth pending byte and is dropped.
    send(8'hA5, 1);
    for (int i = 1; i <= 9; i++) begin
      wr_data = 8'(i);
      wr_en_v[sel] = 1'b1;
      if (i <= 8) push_frame(8'(i));
      tick();
      if (i == 7) chk("full_at7", full_v[sel], 0);
      if (i == 8) begin
        chk("full_at8", full_v[sel], 1);
        chk("level_at8", lvl_m(), 8);
        chk("ovf_at8", ovf_v[sel], 0);
      end
      if (i == 9) begin
        chk("ovf_at9", ovf_v[sel], 1);
        chk("level_at9", lvl_m(), 8);
      end
    end
    wr_en_v = '0;
    repeat (95) tick();
    chk("ovf_sticky", ovf_v[sel], 1);
    chk("empty_after_ovf", empty_v[sel], 1);

    // Async reset mid-frame while bytes are pending.
    send(8'h00, 1);
    send(8'h11, 0);
    send(8'h22, 0);
    repeat (3) tick();
    chk("pre_rst_level", lvl_m(), 2);
    chk("pre_rst_tx", tx_v[sel], 0);
    mon_on = 0;
    rst = 1'b0;
    #1;
    chk_reset_state("midrst");
    exp_q.delete();
    @(negedge Dclk);
    rst = 1'b1;
    mon_on = 1;
    repeat (4) tick();

    // Even then odd parity on 0x07.
    sel = 1;
    send(8'h07, 1);
    repeat (14) tick();
    sel = 2;
    send(8'h07, 1);
    repeat (14) tick();

    // Oversample 4, two stop bits.
    sel = 3;
    send(8'h80, 1);
    repeat (50) tick();
    send(8'h80, 1);
    send(8'h55, 0);
    repeat (17) tick();
    chk("os_bit3_tx", tx_v[sel], 0);
    chk("os_bit3_level", lvl_m(), 1);
    mon_on = 0;
    #2;
    rst = 1'b0;
    #1;
    chk("os_rst_tx", tx_v[sel], 1);
    chk("os_rst_level", lvl_m(), 0);
    chk("os_rst_busy", busy_v[sel], 0);
    chk("os_rst_empty", empty_v[sel], 1);
    exp_q.delete();
    @(negedge Dclk);
    rst = 1'b1;
    mon_on = 1;
    send(8'h3C, 1);
    repeat (50) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
